// File: rtl/edge_burst_gen.sv
// Edge burst generator: on start, emits N pulses of He high / Le low cycles,
// reports rises, completion/cancel pulses, and a latched K-in-W rise prediction.
module edge_burst_gen #(
    parameter int W  = 5,
    parameter int K  = 3,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CW-1:0] i_cfg_count,
    input  logic [CW-1:0] i_cfg_high,
    input  logic [CW-1:0] i_cfg_low,
    output logic          o_out_sig,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_aborted,
    output logic [CW-1:0] o_rise_cnt,
    output logic          o_predict_hit
);

    // state  | meaning
    // IDLE   | waiting for start; outputs hold last burst results
    // HIGH   | out_sig high, timer counting the high phase
    // LOW    | out_sig low between pulses, more rises remain
    // TAIL   | out_sig low after the final pulse, done follows expiry
    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_TAIL
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_tmr,  w_tmr_nxt;
    logic [CW-1:0] r_left, w_left_nxt;
    logic [CW-1:0] r_he,   w_he_nxt;
    logic [CW-1:0] r_le,   w_le_nxt;
    logic [CW-1:0] r_rise, w_rise_nxt;
    logic          r_out,  w_out_nxt;
    logic          r_done, w_done_nxt;
    logic          r_abt,  w_abt_nxt;
    logic          r_pred, w_pred_nxt;

    logic [CW-1:0] w_cfg_he;
    logic [CW-1:0] w_cfg_le;
    logic [63:0]   w_span;
    logic          w_pred_calc;

    // Span of K rises is (K-1) full periods plus the cycle of the last rise.
    always_comb begin
        w_cfg_he    = (i_cfg_high == '0) ? ONE : i_cfg_high;
        w_cfg_le    = (i_cfg_low == '0) ? ONE : i_cfg_low;
        w_span      = 64'(K - 1) * (64'(w_cfg_he) + 64'(w_cfg_le)) + 64'd1;
        w_pred_calc = (64'(i_cfg_count) >= 64'(K)) && (w_span <= 64'(W));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_left_nxt  = r_left;
        w_he_nxt    = r_he;
        w_le_nxt    = r_le;
        w_rise_nxt  = r_rise;
        w_out_nxt   = r_out;
        w_pred_nxt  = r_pred;
        w_done_nxt  = 1'b0;
        w_abt_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_he_nxt   = w_cfg_he;
                    w_le_nxt   = w_cfg_le;
                    w_rise_nxt = '0;
                    w_pred_nxt = w_pred_calc;
                    if (i_cfg_count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_HIGH;
                        w_out_nxt   = 1'b1;
                        w_rise_nxt  = ONE;
                        w_tmr_nxt   = w_cfg_he - ONE;
                        w_left_nxt  = i_cfg_count - ONE;
                    end
                end
            end
            S_HIGH: begin
                if (r_tmr == '0) begin
                    w_out_nxt   = 1'b0;
                    w_tmr_nxt   = r_le - ONE;
                    w_state_nxt = (r_left != '0) ? S_LOW : S_TAIL;
                end else begin
                    w_tmr_nxt = r_tmr - ONE;
                end
            end
            S_LOW: begin
                if (r_tmr == '0) begin
                    w_out_nxt   = 1'b1;
                    w_state_nxt = S_HIGH;
                    w_tmr_nxt   = r_he - ONE;
                    w_left_nxt  = r_left - ONE;
                    w_rise_nxt  = r_rise + ONE;
                end else begin
                    w_tmr_nxt = r_tmr - ONE;
                end
            end
            S_TAIL: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = 1'b0;
            end
        endcase

        // Cancel overrides whatever the active phase would have done, including a rise.
        if (r_state != S_IDLE && i_abort) begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = 1'b0;
            w_abt_nxt   = 1'b1;
            w_done_nxt  = 1'b0;
            w_rise_nxt  = r_rise;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_left  <= '0;
            r_he    <= '0;
            r_le    <= '0;
            r_rise  <= '0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
            r_abt   <= 1'b0;
            r_pred  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_left  <= w_left_nxt;
            r_he    <= w_he_nxt;
            r_le    <= w_le_nxt;
            r_rise  <= w_rise_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
            r_abt   <= w_abt_nxt;
            r_pred  <= w_pred_nxt;
        end
    end

    assign o_out_sig     = r_out;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_aborted     = r_abt;
    assign o_rise_cnt    = r_rise;
    assign o_predict_hit = r_pred;

endmodule

// File: tb/tb_edge_burst_gen.sv
// Randomized bench for edge_burst_gen: expected waveforms come from the burst
// period arithmetic, and out_sig is looped back into a K-in-W rise window check.
module tb_edge_burst_gen;

    localparam int W  = 5;
    localparam int K  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] cfg_count, cfg_high, cfg_low;
    logic          out_sig, busy, done, aborted, predict_hit;
    logic [CW-1:0] rise_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_rise_last = 0;
    int exp_pred_last = 0;

    always #5 clk = ~clk;

    edge_burst_gen #(.W(W), .K(K), .CW(CW)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_cfg_count  (cfg_count),
        .i_cfg_high   (cfg_high),
        .i_cfg_low    (cfg_low),
        .o_out_sig    (out_sig),
        .o_busy       (busy),
        .o_done       (done),
        .o_aborted    (aborted),
        .o_rise_cnt   (rise_cnt),
        .o_predict_hit(predict_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pred_model(input int n, input int h, input int l);
        return ((n >= K) && ((K - 1) * (eff(h) + eff(l)) + 1 <= W)) ? 1 : 0;
    endfunction

    // Cycle c = period following the c-th edge after the start edge.
    task automatic run_burst(input int n, input int h, input int l,
                             input int ab, input int rs, input bit loop_chk);
        int p, len, term, last, pexp, rise_t, hits, rc;
        int eo, eb, ed, ea, er, ep;
        int hist[$];
        p    = eff(h) + eff(l);
        len  = n * p;
        pexp = pred_model(n, h, l);
        term = (ab > 0) ? ab : ((rs > 0) ? rs : 0);
        rise_t = (term > 0) ? (((term - 1) / p + 1 < n) ? (term - 1) / p + 1 : n) : n;
        last = ((term > 0) ? term : len) + 3;
        rst = 1'b0; abort = 1'b0; start = 1'b1;
        cfg_count = CW'(n); cfg_high = CW'(h); cfg_low = CW'(l);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start     = (c <= len) && (term == 0 || c <= term) && ($urandom_range(0, 3) == 0);
            cfg_count = CW'($urandom_range(0, 255));
            cfg_high  = CW'($urandom_range(0, 255));
            cfg_low   = CW'($urandom_range(0, 255));
            abort     = (c == ab);
            rst       = (c == rs);
            @(negedge clk);
            if (term == 0 || c <= term) begin
                eb = (c <= len) ? 1 : 0;
                eo = (eb == 1 && ((c - 1) % p) < eff(h)) ? 1 : 0;
                ed = (c == len + 1) ? 1 : 0;
                ea = 0;
                er = (eb == 1) ? (c - 1) / p + 1 : n;
                ep = pexp;
            end else begin
                eo = 0; eb = 0; ed = 0;
                ea = (ab > 0 && c == term + 1) ? 1 : 0;
                er = (rs > 0) ? 0 : rise_t;
                ep = (rs > 0) ? 0 : pexp;
            end
            chk("out_sig", out_sig, eo);
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("aborted", aborted, ea);
            chk("rise_cnt", rise_cnt, er);
            chk("predict_hit", predict_hit, ep);
            hist.push_back(int'(out_sig));
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        if (rs > 0) begin
            exp_rise_last = 0; exp_pred_last = 0;
        end else begin
            exp_rise_last = rise_t; exp_pred_last = pexp;
        end
        if (loop_chk) begin
            hits = 0;
            for (int i = 0; i < hist.size(); i++) begin
                rc = 0;
                for (int j = i; j < i + W && j < hist.size(); j++)
                    if (hist[j] == 1 && (j == 0 || hist[j-1] == 0)) rc++;
                if (rc >= K) hits = 1;
            end
            chk("loop_hits", hits, pexp);
        end
    endtask

    initial begin
        int n, h, l, ab, rs, len;
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        cfg_count = 8'd3; cfg_high = 8'd1; cfg_low = 8'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_sig", out_sig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_rise_cnt", rise_cnt, 0);
        chk("rst_predict_hit", predict_hit, 0);

        run_burst(3, 1, 1, 0, 0, 1);
        run_burst(3, 2, 2, 0, 0, 1);
        run_burst(2, 1, 1, 0, 0, 1);
        run_burst(0, 1, 1, 0, 0, 1);
        run_burst(5, 1, 1, 4, 0, 0);

        // start and abort together while idle: nothing may happen
        start = 1'b1; abort = 1'b1; cfg_count = 8'd4; cfg_high = 8'd1; cfg_low = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sa_busy", busy, 0);
            chk("sa_out_sig", out_sig, 0);
            chk("sa_aborted", aborted, 0);
            chk("sa_done", done, 0);
            chk("sa_rise_cnt", rise_cnt, exp_rise_last);
            chk("sa_predict_hit", predict_hit, exp_pred_last);
            @(posedge clk); #1;
        end
        @(negedge clk);

        run_burst(3, 1, 1, 0, 3, 0);
        run_burst(3, 1, 1, 0, 0, 1);
        run_burst(2, 0, 0, 0, 0, 1);
        run_burst(1, 255, 0, 0, 0, 0);
        run_burst(255, 1, 1, 0, 0, 0);

        for (int hh = 1; hh <= 3; hh++)
            for (int ll = 1; ll <= 3; ll++)
                for (int nn = 0; nn <= 4; nn++)
                    run_burst(nn, hh, ll, 0, 0, 1);

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 6);
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 4);
            len = n * (eff(h) + eff(l));
            ab = 0; rs = 0;
            if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, len);
            else if (n > 0 && $urandom_range(0, 5) == 0) rs = $urandom_range(1, len);
            run_burst(n, h, l, ab, rs, (ab == 0 && rs == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_burst_gen.md
EDGE_BURST_GEN -- requirements
Module: edge_burst_gen

Interface
REQ-001 Parameter W, default 5: sliding-window length in cycles used for the hit prediction.
REQ-002 Parameter K, default 3: rising-edge threshold used for the hit prediction.
REQ-003 Parameter CW, default 8: width of all configuration fields and of rise_cnt.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  burst request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous burst cancel.
REQ-008 cfg_count  input  CW  number of rising edges to emit (N).
REQ-009 cfg_high  input  CW  high time per pulse in cycles (H).
REQ-010 cfg_low  input  CW  low time after each pulse in cycles (L).
REQ-011 out_sig  output  1  generated pulse train; registered, glitch-free.
REQ-012 busy  output  1  high while state != IDLE.
REQ-013 done  output  1  one-cycle pulse on normal burst completion.
REQ-014 aborted  output  1  one-cycle pulse when a burst is cancelled.
REQ-015 rise_cnt  output  CW  rising edges emitted in the current or last burst.
REQ-016 predict_hit  output  1  latched prediction: the burst contains K rises within W cycles.

Function
REQ-017 FSM states SHALL be IDLE, HIGH, LOW and TAIL.
REQ-018 In IDLE with start=1 and abort=0: latch cfg_*, clear rise_cnt, update predict_hit, and set out_sig=1 with state HIGH on the same edge (first high cycle = cycle 1 after the start edge).
REQ-019 Effective He = max(cfg_high,1) and Le = max(cfg_low,1); zero values SHALL be treated as 1.
REQ-020 cfg_count=0 at start: no out_sig activity, busy stays 0, done pulses the next cycle, predict_hit=0.
REQ-021 HIGH: out_sig=1 for exactly He cycles, then out_sig=0; rise_cnt increments on each 0->1 transition of out_sig.
REQ-022 After a pulse: state LOW if rises remain, otherwise TAIL; both hold out_sig=0 for exactly Le cycles.
REQ-023 LOW expiry: out_sig=1 and state HIGH on the same edge.
REQ-024 TAIL expiry: done=1 for one cycle and state IDLE; done is therefore high in cycle 1+N*(He+Le) after the start edge, with busy already 0 in that cycle.
REQ-025 predict_hit = (N >= K) && ((K-1)*(He+Le)+1 <= W), evaluated in at least 32-bit arithmetic without overflow; held until the next accepted start.
REQ-026 start while busy is ignored, with no effect on state or on latched configuration.
REQ-027 abort in any non-IDLE state: out_sig=0, state IDLE, aborted=1 for one cycle, no done; rise_cnt holds.
REQ-028 abort and start in the same IDLE cycle: abort wins; the start is dropped and aborted stays 0.
REQ-029 Changes to cfg_* during a burst SHALL NOT affect that burst.
REQ-030 Internal counters SHALL be CW bits wide; a value of 2^CW-1 SHALL run to completion without wrap.

Reset
REQ-031 rst=1 at a clock edge forces state IDLE and drives out_sig, busy, done, aborted, predict_hit and rise_cnt to 0 on that edge, including mid-burst.
REQ-032 When rst and start are high together, rst wins; the first start is honoured on the first edge with rst=0.

Verification
REQ-033 N=3, H=1, L=1: out_sig=1,0,1,0,1,0 over cycles 1-6; done in cycle 7; rise_cnt=3; predict_hit=1.
REQ-034 N=3, H=2, L=2: out_sig=1,1,0,0 x3; done in cycle 13; predict_hit=0 (9>5).
REQ-035 N=2, H=1, L=1: done in cycle 5; predict_hit=0 (N<K). N=0: done in cycle 1; busy never set.
REQ-036 Burst N=5, H=1, L=1 with abort in cycle 4: out_sig=0 and aborted=1 on the next edge; no done; rise_cnt=2. Start+abort together in IDLE: no burst, no pulses.
REQ-037 rst pulse in cycle 3 of N=3, H=1, L=1: all outputs 0 on the next edge; a subsequent start completes a normal burst.
REQ-038 Loopback: out_sig feeds a seqcheck instance (W=5, K=3); the number of hit pulses equals 1 whenever predict_hit=1 and 0 otherwise, checked for H,L in 1..3 and N in 0..4.
